// File: rtl/mc_ifetch_pkg.sv
// rtl/mc_ifetch_pkg.sv - shared types and constants for the instruction-fetch responder
package mc_ifetch_pkg;

  // Default RAM / pc address width
  localparam int MCIF_ADDR_W = 32;

  // Bytes per instruction word; the byte sequencer below is only built for 4
  localparam int MCIF_WORD_BYTES = 4;

  // Beat counter value on which the last byte lane is captured
  localparam logic [2:0] MCIF_LAST_CNT = 3'(MCIF_WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } mcif_state_t;

  // Little-endian word assembly: the three buffered low lanes plus the byte on the bus as lane 3
  function automatic logic [31:0] mcif_assemble(input logic [23:0] low_lanes,
                                                input logic [7:0]  top_lane);
    return {top_lane, low_lanes};
  endfunction

endpackage

// File: rtl/mc_ifetch_if.sv
// rtl/mc_ifetch_if.sv - ICache miss request/response and byte-wide RAM port bundle
interface mc_ifetch_if
  import mc_ifetch_pkg::*;
#(
  parameter int ADDR_W = MCIF_ADDR_W
);

  // ICache side
  logic              ins_flag_mc;
  logic [ADDR_W-1:0] pc_mc;
  logic              ins_flag;
  logic [31:0]       ins;
  logic [ADDR_W-1:0] ins_pc;

  // RAM port side
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_din;

  // Fetch responder view
  modport slave (
    input  ins_flag_mc,
    input  pc_mc,
    input  bus_gnt,
    input  mem_din,
    output ins_flag,
    output ins,
    output ins_pc,
    output bus_req,
    output mem_a
  );

  // ICache / arbiter / RAM view
  modport master (
    output ins_flag_mc,
    output pc_mc,
    output bus_gnt,
    output mem_din,
    input  ins_flag,
    input  ins,
    input  ins_pc,
    input  bus_req,
    input  mem_a
  );

endinterface

// File: rtl/mc_ifetch.sv
// rtl/mc_ifetch.sv - serves ICache misses by reading one word as four byte reads
module mc_ifetch
  import mc_ifetch_pkg::*;
#(
  parameter int ADDR_W = MCIF_ADDR_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rdy_i,
  input  logic       jp_wrong_i,
  mc_ifetch_if.slave bus_if
);

  mcif_state_t       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [23:0]       lanes_q, lanes_d;
  logic [31:0]       ins_q, ins_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
  logic              ins_flag_q, ins_flag_d;

  logic              accept;

  // A miss is taken only from IDLE, with the port granted and no flush pending
  assign accept = (state_q == ST_IDLE) & bus_if.ins_flag_mc & bus_if.bus_gnt & ~jp_wrong_i;

  // State register; rdy low freezes everything, reset still wins asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      base_q     <= '0;
      mem_a_q    <= '0;
      lanes_q    <= 24'd0;
      ins_q      <= 32'd0;
      ins_pc_q   <= '0;
      ins_flag_q <= 1'b0;
    end else if (rdy_i) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      mem_a_q    <= mem_a_d;
      lanes_q    <= lanes_d;
      ins_q      <= ins_d;
      ins_pc_q   <= ins_pc_d;
      ins_flag_q <= ins_flag_d;
    end
  end

  // Next-state: issue byte 0 on accept, capture one lane per READ beat, pulse valid in DONE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    mem_a_d    = mem_a_q;
    lanes_d    = lanes_q;
    ins_d      = ins_q;
    ins_pc_d   = ins_pc_q;
    ins_flag_d = ins_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_READ;
          base_d  = bus_if.pc_mc;
          mem_a_d = bus_if.pc_mc;
          cnt_d   = 3'd1;
        end
      end

      ST_READ: begin
        if (jp_wrong_i) begin
          // Mispredict: drop the fetch, the partial lanes are simply overwritten next time
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          case (cnt_q)
            3'd1:    lanes_d[7:0]   = bus_if.mem_din;
            3'd2:    lanes_d[15:8]  = bus_if.mem_din;
            3'd3:    lanes_d[23:16] = bus_if.mem_din;
            default: ;
          endcase
          if (cnt_q == MCIF_LAST_CNT) begin
            ins_d      = mcif_assemble(lanes_q, bus_if.mem_din);
            ins_pc_d   = base_q;
            ins_flag_d = 1'b1;
            state_d    = ST_DONE;
            cnt_d      = 3'd0;
          end else begin
            mem_a_d = base_q + ADDR_W'(cnt_q);
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end

      ST_DONE: begin
        // One dead cycle so the ICache can fill before the miss line is looked at again
        ins_flag_d = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // A flush in the delivery cycle must hide the word from the ICache
  assign bus_if.ins_flag = ins_flag_q & ~jp_wrong_i;
  assign bus_if.ins      = ins_q;
  assign bus_if.ins_pc   = ins_pc_q;
  assign bus_if.mem_a    = mem_a_q;
  assign bus_if.bus_req  = (state_q == ST_READ) |
                           ((state_q == ST_IDLE) & bus_if.ins_flag_mc & ~jp_wrong_i);

endmodule
